// File: rtl/hamming_dec_sched_pkg.sv
// Shared Hamming(7,4) types, widths and syndrome/correction helpers
// for the two-channel decoder scheduler.
package hamming_dec_sched_pkg;

   localparam int unsigned CODE_W = 7;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned SYN_W  = 3;

   typedef logic [CODE_W-1:0] code_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [SYN_W-1:0]  syn_t;

   // Stage-1 payload: granted codeword and its source channel.
   typedef struct packed {
      logic  ch;
      code_t code;
   } s1_t;

   // Stage-2 payload: decoded result as presented on the output port.
   typedef struct packed {
      logic  ch;
      data_t data;
      syn_t  syn;
      logic  corr;
   } res_t;

   function automatic syn_t calc_syndrome(input code_t c);
      syn_t s;
      s[0] = c[6] ^ c[4] ^ c[2] ^ c[0];
      s[1] = c[6] ^ c[5] ^ c[2] ^ c[1];
      s[2] = c[6] ^ c[5] ^ c[4] ^ c[3];
      return s;
   endfunction

   // A nonzero syndrome k points at codeword bit k-1; no double-error detection.
   function automatic code_t correct_code(input code_t c, input syn_t s);
      code_t fixed;
      fixed = c;
      if (s != '0) begin
         fixed[s - SYN_W'(1)] = ~c[s - SYN_W'(1)];
      end
      return fixed;
   endfunction

   function automatic data_t extract_data(input code_t c);
      return {c[6], c[5], c[4], c[2]};
   endfunction

endpackage

// File: rtl/hamming_dec_sched_corrector.sv
// Combinational Hamming(7,4) single-error corrector: syndrome plus
// the corrected codeword.
module hamming_corrector
   import hamming_dec_sched_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [CODE_W-1:0] fixed,
   output logic [SYN_W-1:0]  syn
);

   always_comb begin
      syn   = calc_syndrome(code);
      fixed = correct_code(code, syn);
   end

endmodule

// File: rtl/hamming_dec_sched.sv
// Two-channel round-robin Hamming(7,4) decoder with a two-stage
// elastic pipeline and saturating per-channel corrected-word counters.
module hamming_dec_sched
   import hamming_dec_sched_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ch0_valid,
   input  logic [CODE_W-1:0] ch0_code,
   output logic              ch0_ready,
   input  logic              ch1_valid,
   input  logic [CODE_W-1:0] ch1_code,
   output logic              ch1_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_ch,
   output logic [DATA_W-1:0] out_data,
   output logic [SYN_W-1:0]  out_syn,
   output logic              out_corr,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   logic  last_ch;
   logic  s1_valid;
   s1_t   s1_q;
   s1_t   s1_d;
   res_t  res_q;
   res_t  res_d;
   logic  s2_load;
   logic  s1_open;
   logic  gnt_any;
   logic  gnt_ch;
   logic  take;
   logic  xfer;
   code_t fixed;
   syn_t  syn;

   // Grant: alternate on a tie, otherwise serve whichever channel is valid.
   always_comb begin
      s2_load = !out_valid || out_ready;
      s1_open = !s1_valid || s2_load;
      gnt_any = 1'b0;
      gnt_ch  = 1'b0;
      if (ch0_valid && ch1_valid) begin
         gnt_any = 1'b1;
         gnt_ch  = ~last_ch;
      end else if (ch0_valid) begin
         gnt_any = 1'b1;
         gnt_ch  = 1'b0;
      end else if (ch1_valid) begin
         gnt_any = 1'b1;
         gnt_ch  = 1'b1;
      end
      take      = gnt_any && s1_open && !rst;
      ch0_ready = take && !gnt_ch;
      ch1_ready = take && gnt_ch;
      s1_d.ch   = gnt_ch;
      s1_d.code = gnt_ch ? ch1_code : ch0_code;
   end

   // Stage 1 register and last-grant pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         last_ch  <= 1'b1;
      end else begin
         if (s1_open) begin
            s1_valid <= take;
            if (take) begin
               s1_q <= s1_d;
            end
         end
         if (take) begin
            last_ch <= gnt_ch;
         end
      end
   end

   hamming_corrector u_corrector (
      .code  (s1_q.code),
      .fixed (fixed),
      .syn   (syn)
   );

   always_comb begin
      res_d.ch   = s1_q.ch;
      res_d.data = extract_data(fixed);
      res_d.syn  = syn;
      res_d.corr = (syn != '0);
   end

   // Stage 2 output register; fields hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         res_q     <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            res_q <= res_d;
         end
      end
   end

   assign out_ch   = res_q.ch;
   assign out_data = res_q.data;
   assign out_syn  = res_q.syn;
   assign out_corr = res_q.corr;

   assign xfer = out_valid && out_ready;

   // Saturating corrected-word counters, bumped on transfer of a corrected result.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (xfer && res_q.corr) begin
         if (!res_q.ch && (cnt0 != {CNT_W{1'b1}})) begin
            cnt0 <= cnt0 + CNT_W'(1);
         end
         if (res_q.ch && (cnt1 != {CNT_W{1'b1}})) begin
            cnt1 <= cnt1 + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hamming_dec_sched.sv
// Scoreboard bench for hamming_dec_sched: a negedge monitor models
// decode, arbitration order and counters; tasks drive each scenario.
module tb_hamming_dec_sched;

   localparam int unsigned CNT_W = 4;

   typedef struct packed {
      logic       ch;
      logic [3:0] data;
      logic [2:0] syn;
      logic       corr;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             ch0_valid;
   logic [6:0]       ch0_code;
   logic             ch0_ready;
   logic             ch1_valid;
   logic [6:0]       ch1_code;
   logic             ch1_ready;
   logic             out_valid;
   logic             out_ready;
   logic             out_ch;
   logic [3:0]       out_data;
   logic [2:0]       out_syn;
   logic             out_corr;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   int         vectors     = 0;
   int         miscompares = 0;
   exp_t       sb[$];
   int         seen_ch[$];
   logic       exp_last    = 1'b1;
   logic [CNT_W-1:0] exp_cnt0 = '0;
   logic [CNT_W-1:0] exp_cnt1 = '0;
   logic       hs0 = 1'b0;
   logic       hs1 = 1'b0;
   int         hs_total = 0;

   always #5 clk = ~clk;

   hamming_dec_sched #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .ch0_valid (ch0_valid),
      .ch0_code  (ch0_code),
      .ch0_ready (ch0_ready),
      .ch1_valid (ch1_valid),
      .ch1_code  (ch1_code),
      .ch1_ready (ch1_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .out_syn   (out_syn),
      .out_corr  (out_corr),
      .cnt0      (cnt0),
      .cnt1      (cnt1)
   );

   // Reference decode: syndrome is the XOR of 1-based positions of set bits.
   function automatic exp_t ref_decode(input logic [6:0] code, input logic ch);
      exp_t       e;
      logic [2:0] s;
      logic [6:0] f;
      int         idx;
      s = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (code[i]) s = s ^ 3'(i + 1);
      end
      f = code;
      if (s != 3'd0) begin
         idx    = int'(s) - 1;
         f[idx] = ~f[idx];
      end
      e.ch   = ch;
      e.data = {f[6], f[5], f[4], f[2]};
      e.syn  = s;
      e.corr = (s != 3'd0);
      return e;
   endfunction

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] c;
      c    = 7'd0;
      c[6] = d[3];
      c[5] = d[2];
      c[4] = d[1];
      c[2] = d[0];
      c[0] = c[6] ^ c[4] ^ c[2];
      c[1] = c[6] ^ c[5] ^ c[2];
      c[3] = c[6] ^ c[5] ^ c[4];
      return c;
   endfunction

   function automatic logic [6:0] gen_code(input logic single_err);
      logic [6:0] c;
      int         idx;
      c = encode(4'($urandom));
      if (single_err) begin
         idx    = $urandom_range(6, 0);
         c[idx] = ~c[idx];
      end
      return c;
   endfunction

   // Monitor: scoreboard, arbitration order, occupancy and counter model.
   always @(negedge clk) begin
      exp_t e;
      hs0 = 1'b0;
      hs1 = 1'b0;
      if (rst) begin
         vectors++;
         if ((ch0_ready !== 1'b0) || (ch1_ready !== 1'b0)) begin
            miscompares++;
            $display("FAIL reset_ready: got %b%b want 00", ch0_ready, ch1_ready);
         end
         sb.delete();
         exp_cnt0 = '0;
         exp_cnt1 = '0;
         exp_last = 1'b1;
      end else begin
         vectors++;
         if ((ch0_ready && !ch0_valid) || (ch1_ready && !ch1_valid) || (ch0_ready && ch1_ready)) begin
            miscompares++;
            $display("FAIL ready_onehot: got ready=%b%b valid=%b%b", ch0_ready, ch1_ready, ch0_valid, ch1_valid);
         end
         if (ch0_valid && ch1_valid && (ch0_ready || ch1_ready)) begin
            vectors++;
            if (ch1_ready !== ~exp_last) begin
               miscompares++;
               $display("FAIL rr_grant: got ch%0d want ch%0d", ch1_ready, ~exp_last);
            end
         end
         vectors++;
         if ((cnt0 !== exp_cnt0) || (cnt1 !== exp_cnt1)) begin
            miscompares++;
            $display("FAIL counters: got %0d/%0d want %0d/%0d", cnt0, cnt1, exp_cnt0, exp_cnt1);
         end
         if (out_valid === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL spurious_out: got ch=%0d data=%h with empty scoreboard", out_ch, out_data);
            end else if ({out_ch, out_data, out_syn, out_corr} !== sb[0]) begin
               miscompares++;
               $display("FAIL out_fields: got %h want %h", {out_ch, out_data, out_syn, out_corr}, sb[0]);
            end
         end
         if ((out_valid === 1'b1) && (out_ready === 1'b1) && (sb.size() > 0)) begin
            e = sb.pop_front();
            seen_ch.push_back(int'(e.ch));
            if (e.corr && !e.ch && (exp_cnt0 != {CNT_W{1'b1}})) exp_cnt0 = exp_cnt0 + 1'b1;
            if (e.corr && e.ch && (exp_cnt1 != {CNT_W{1'b1}})) exp_cnt1 = exp_cnt1 + 1'b1;
         end
         if (ch0_valid && ch0_ready) begin
            sb.push_back(ref_decode(ch0_code, 1'b0));
            exp_last = 1'b0;
            hs0      = 1'b1;
            hs_total++;
         end
         if (ch1_valid && ch1_ready) begin
            sb.push_back(ref_decode(ch1_code, 1'b1));
            exp_last = 1'b1;
            hs1      = 1'b1;
            hs_total++;
         end
         vectors++;
         if (sb.size() > 2) begin
            miscompares++;
            $display("FAIL occupancy: got %0d words in flight want <=2", sb.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      ch0_valid = 1'b0;
      ch1_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      seen_ch.delete();
      hs_total = 0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      ch0_valid = 1'b0;
      ch1_valid = 1'b0;
      while (((sb.size() != 0) || (out_valid === 1'b1)) && (n < 200)) begin
         tick();
         n++;
      end
      vectors++;
      if ((sb.size() != 0) || (out_valid !== 1'b0)) begin
         miscompares++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      ch0_valid = 1'b1;
      ch1_valid = 1'b1;
      ch0_code  = 7'h55;
      ch1_code  = 7'h2a;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({out_valid, out_ch, out_data, out_syn, out_corr} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want 0", {out_valid, out_ch, out_data, out_syn, out_corr});
      end
      vectors++;
      if ((cnt0 !== '0) || (cnt1 !== '0)) begin
         miscompares++;
         $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt0, cnt1);
      end
      vectors++;
      if ((ch0_ready !== 1'b0) || (ch1_ready !== 1'b0)) begin
         miscompares++;
         $display("FAIL reset_cycle_ready: got %b%b want 00", ch0_ready, ch1_ready);
      end
      tick();
      ch0_valid = 1'b0;
      ch1_valid = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic test_clean();
      do_reset();
      ch0_code  = 7'b1010101;
      ch0_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (ch0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL clean_ready: got %b want 1", ch0_ready);
      end
      tick();
      ch0_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL clean_early: got out_valid=%b want 0", out_valid);
      end
      @(negedge clk);
      vectors++;
      if ({out_valid, out_ch, out_data, out_syn, out_corr} !== {1'b1, 1'b0, 4'b1011, 3'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL clean_result: got v=%b ch=%0d d=%b s=%0d c=%b want v=1 ch=0 d=1011 s=0 c=0",
                  out_valid, out_ch, out_data, out_syn, out_corr);
      end
      drain();
      vectors++;
      if (cnt0 !== '0) begin
         miscompares++;
         $display("FAIL clean_cnt0: got %0d want 0", cnt0);
      end
   endtask

   task automatic test_corrected();
      do_reset();
      ch1_code  = 7'b1110101;
      ch1_valid = 1'b1;
      tick();
      ch1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({out_valid, out_ch, out_data, out_syn, out_corr} !== {1'b1, 1'b1, 4'b1011, 3'd6, 1'b1}) begin
         miscompares++;
         $display("FAIL corr_result: got v=%b ch=%0d d=%b s=%0d c=%b want v=1 ch=1 d=1011 s=6 c=1",
                  out_valid, out_ch, out_data, out_syn, out_corr);
      end
      drain();
      vectors++;
      if ((cnt1 !== 4'd1) || (cnt0 !== 4'd0)) begin
         miscompares++;
         $display("FAIL corr_cnt: got %0d/%0d want 0/1", cnt0, cnt1);
      end
   endtask

   task automatic test_alternate();
      do_reset();
      ch0_code  = gen_code(1'b0);
      ch1_code  = gen_code(1'b1);
      ch0_valid = 1'b1;
      ch1_valid = 1'b1;
      repeat (6) tick();
      drain();
      vectors++;
      if (seen_ch.size() != 6) begin
         miscompares++;
         $display("FAIL alt_count: got %0d want 6", seen_ch.size());
      end
      for (int i = 0; i < seen_ch.size(); i++) begin
         vectors++;
         if (seen_ch[i] != (i % 2)) begin
            miscompares++;
            $display("FAIL alt_order[%0d]: got ch%0d want ch%0d", i, seen_ch[i], i % 2);
         end
      end
   endtask

   task automatic test_stall();
      int stalled_hs;
      do_reset();
      out_ready = 1'b0;
      ch0_code  = gen_code($urandom_range(1, 0) == 1);
      ch1_code  = gen_code($urandom_range(1, 0) == 1);
      ch0_valid = 1'b1;
      ch1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (hs0) ch0_code = gen_code($urandom_range(1, 0) == 1);
         if (hs1) ch1_code = gen_code($urandom_range(1, 0) == 1);
      end
      stalled_hs = hs_total;
      vectors++;
      if (stalled_hs != 2) begin
         miscompares++;
         $display("FAIL stall_buffered: got %0d want 2", stalled_hs);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (hs0) ch0_code = gen_code($urandom_range(1, 0) == 1);
         if (hs1) ch1_code = gen_code($urandom_range(1, 0) == 1);
      end
      drain();
      vectors++;
      if (seen_ch.size() != hs_total) begin
         miscompares++;
         $display("FAIL stall_lost: got %0d out want %0d in", seen_ch.size(), hs_total);
      end
      for (int i = 0; i < seen_ch.size(); i++) begin
         vectors++;
         if (seen_ch[i] != (i % 2)) begin
            miscompares++;
            $display("FAIL stall_order[%0d]: got ch%0d want ch%0d", i, seen_ch[i], i % 2);
         end
      end
   endtask

   task automatic test_saturation();
      int n0 = 0;
      int guard = 0;
      do_reset();
      ch0_code  = gen_code(1'b1);
      ch0_valid = 1'b1;
      while ((n0 < 17) && (guard < 100)) begin
         tick();
         guard++;
         if (hs0) begin
            n0++;
            ch0_code = gen_code(1'b1);
         end
      end
      ch0_valid = 1'b0;
      drain();
      vectors++;
      if (cnt0 !== 4'd15) begin
         miscompares++;
         $display("FAIL sat_cnt0: got %0d want 15", cnt0);
      end
   endtask

   task automatic test_random();
      do_reset();
      ch0_valid = 1'b0;
      ch1_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!ch0_valid || hs0) begin
            ch0_valid = ($urandom_range(3, 0) != 0);
            ch0_code  = 7'($urandom);
         end
         if (!ch1_valid || hs1) begin
            ch1_valid = ($urandom_range(3, 0) != 0);
            ch1_code  = 7'($urandom);
         end
         out_ready = ($urandom_range(2, 0) != 0);
         tick();
      end
      drain();
      vectors++;
      if (seen_ch.size() != hs_total) begin
         miscompares++;
         $display("FAIL rand_lost: got %0d out want %0d in", seen_ch.size(), hs_total);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      out_ready = 1'b0;
      ch0_code  = gen_code(1'b1);
      ch0_valid = 1'b1;
      repeat (3) tick();
      vectors++;
      if ((out_valid !== 1'b1) || (sb.size() != 2)) begin
         miscompares++;
         $display("FAIL mid_fill: got out_valid=%b inflight=%0d want 1/2", out_valid, sb.size());
      end
      rst       = 1'b1;
      out_ready = 1'b1;
      ch0_valid = 1'b0;
      tick();
      rst       = 1'b0;
      ch0_valid = 1'b1;
      ch1_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if ((out_valid !== 1'b0) || (cnt0 !== '0) || (cnt1 !== '0)) begin
         miscompares++;
         $display("FAIL mid_flush: got v=%b cnt=%0d/%0d want 0 0/0", out_valid, cnt0, cnt1);
      end
      vectors++;
      if ((ch0_ready !== 1'b1) || (ch1_ready !== 1'b0)) begin
         miscompares++;
         $display("FAIL mid_first_tie: got %b%b want 10", ch0_ready, ch1_ready);
      end
      tick();
      drain();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      ch0_valid = 1'b0;
      ch1_valid = 1'b0;
      ch0_code  = 7'd0;
      ch1_code  = 7'd0;
      out_ready = 1'b1;
      test_reset();
      test_clean();
      test_corrected();
      test_alternate();
      test_stall();
      test_saturation();
      test_random();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
